// File: rtl/wb_pkg.sv
// Shared widths and source encoding for the writeback arbiter and its round-robin grant logic.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;
endpackage

// File: rtl/wb_rr_arb.sv
// Two-requester round-robin grant; the source not granted last wins contention.
//   state   | meaning
//   SRC_ALU | ALU was granted last, LSU wins the next contention
//   SRC_LSU | LSU was granted last (reset), ALU wins the next contention
module wb_rr_arb
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_grant,
  output logic lsu_grant
);

  src_e last_grant_q, last_grant_d;
  logic alu_grant_c, lsu_grant_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= SRC_LSU;
    else        last_grant_q <= last_grant_d;
  end

  always_comb begin
    alu_grant_c  = 1'b0;
    lsu_grant_c  = 1'b0;
    last_grant_d = last_grant_q;
    if (alu_valid && lsu_valid) begin
      if (last_grant_q == SRC_LSU) alu_grant_c = 1'b1;
      else                         lsu_grant_c = 1'b1;
    end else if (alu_valid) begin
      alu_grant_c = 1'b1;
    end else if (lsu_valid) begin
      lsu_grant_c = 1'b1;
    end
    if (alu_grant_c) last_grant_d = SRC_ALU;
    if (lsu_grant_c) last_grant_d = SRC_LSU;
  end

  // Gating with rst_n keeps both readies low while reset is held.
  assign alu_grant = alu_grant_c & rst_n;
  assign lsu_grant = lsu_grant_c & rst_n;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into one registered register-file write port and tracks pending destinations.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = wb_pkg::XLEN,
  parameter int NREG = wb_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_dest,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_dest,
  input  logic                  flush,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [XLEN-1:0]       reg_write_data,
  output logic [NREG-1:0]       busy
);

  logic                  xfer;
  logic [REG_ADDR_W-1:0] xfer_dest;
  logic [XLEN-1:0]       xfer_data;

  logic                  reg_write_en_q, reg_write_en_d;
  logic [REG_ADDR_W-1:0] reg_write_dest_q, reg_write_dest_d;
  logic [XLEN-1:0]       reg_write_data_q, reg_write_data_d;
  logic [NREG-1:0]       busy_q, busy_d;

  wb_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .lsu_valid (lsu_valid),
    .alu_grant (alu_ready),
    .lsu_grant (lsu_ready)
  );

  assign xfer      = alu_ready | lsu_ready;
  assign xfer_dest = alu_ready ? alu_dest : lsu_dest;
  assign xfer_data = alu_ready ? alu_data : lsu_data;

  always_comb begin
    reg_write_en_d   = 1'b0;
    reg_write_dest_d = reg_write_dest_q;
    reg_write_data_d = reg_write_data_q;
    if (xfer && (xfer_dest != '0)) begin
      reg_write_en_d   = 1'b1;
      reg_write_dest_d = xfer_dest;
      reg_write_data_d = xfer_data;
    end
  end

  // Priority per bit: flush, then alloc, then clearing transfer; x0 is never pending.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (xfer && (xfer_dest == REG_ADDR_W'(i)))           busy_d[i] = 1'b0;
      if (alloc_valid && (alloc_dest == REG_ADDR_W'(i)))   busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_en_q   <= 1'b0;
      reg_write_dest_q <= '0;
      reg_write_data_q <= '0;
      busy_q           <= '0;
    end else begin
      reg_write_en_q   <= reg_write_en_d;
      reg_write_dest_q <= reg_write_dest_d;
      reg_write_data_q <= reg_write_data_d;
      busy_q           <= busy_d;
    end
  end

  assign reg_write_en   = reg_write_en_q;
  assign reg_write_dest = reg_write_dest_q;
  assign reg_write_data = reg_write_data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and random checks of writeback_arbiter against a behavioural reference model.
module tb_writeback_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0, lsu_valid = 1'b0;
  logic            alu_ready, lsu_ready;
  logic [4:0]      alu_dest = '0, lsu_dest = '0;
  logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
  logic            alloc_valid = 1'b0;
  logic [4:0]      alloc_dest = '0;
  logic            flush = 1'b0;
  logic            reg_write_en;
  logic [4:0]      reg_write_dest;
  logic [XLEN-1:0] reg_write_data;
  logic [NREG-1:0] busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit              alu_turn;
  bit              pend[NREG];
  bit              m_wen;
  logic [4:0]      m_dest;
  logic [XLEN-1:0] m_data;
  bit              g_alu, g_lsu;
  logic [NREG-1:0] m_busy_vec;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .flush(flush),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] busy_vec();
    logic [NREG-1:0] v = '0;
    for (int i = 0; i < NREG; i++) v[i] = pend[i];
    return v;
  endfunction

  task automatic model_reset();
    alu_turn = 1'b1;
    for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
    m_wen = 1'b0; m_dest = '0; m_data = '0;
  endtask

  // One clock: inputs are already applied; check readies, advance model, check registered outputs.
  task automatic step(input string tag);
    logic [4:0] d;
    #1;
    g_alu = alu_valid && (!lsu_valid || alu_turn);
    g_lsu = lsu_valid && (!alu_valid || !alu_turn);
    check({tag, ".alu_ready"}, 64'(alu_ready), 64'(g_alu));
    check({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(g_lsu));
    m_wen = 1'b0;
    d = g_alu ? alu_dest : lsu_dest;
    if (g_alu) alu_turn = 1'b0;
    if (g_lsu) alu_turn = 1'b1;
    if ((g_alu || g_lsu) && d != 0) begin
      m_wen  = 1'b1;
      m_dest = d;
      m_data = g_alu ? alu_data : lsu_data;
      pend[d] = 1'b0;
    end
    if (alloc_valid && alloc_dest != 0) pend[alloc_dest] = 1'b1;
    if (flush) for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".wen"},  64'(reg_write_en),   64'(m_wen));
    check({tag, ".dest"}, 64'(reg_write_dest), 64'(m_dest));
    check({tag, ".data"}, 64'(reg_write_data), 64'(m_data));
    m_busy_vec = busy_vec();
    check({tag, ".busy"}, 64'(busy), 64'(m_busy_vec));
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; alloc_valid = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset state, with valids asserted to confirm readies stay low
    alu_valid = 1; lsu_valid = 1;
    @(posedge clk); #1;
    check("rst.alu_ready", 64'(alu_ready), 64'(0));
    check("rst.lsu_ready", 64'(lsu_ready), 64'(0));
    check("rst.wen", 64'(reg_write_en), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    do_reset();

    // Single ALU write, then idle with held outputs
    alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF;
    step("alu1");
    check("alu1.exp_dest", 64'(reg_write_dest), 64'd5);
    check("alu1.exp_data", 64'(reg_write_data), 64'hDEADBEEF);
    idle_inputs();
    step("alu1_idle");

    // Contention: alternate starting with ALU
    do_reset();
    alu_valid = 1; alu_dest = 1; alu_data = 32'h11;
    lsu_valid = 1; lsu_dest = 2; lsu_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      step("rr");
      check("rr.order", 64'(reg_write_dest), 64'((k % 2 == 0) ? 1 : 2));
    end
    idle_inputs();
    step("rr_idle");

    // Write to x0 consumed without a pulse
    lsu_valid = 1; lsu_dest = 0; lsu_data = 32'h1234;
    step("x0");
    idle_inputs();
    step("x0_idle");

    // alloc 7, clear two cycles later
    alloc_valid = 1; alloc_dest = 7;
    step("alloc7");
    idle_inputs();
    step("busy7_hold");
    alu_valid = 1; alu_dest = 7; alu_data = 32'h77;
    step("clr7");
    check("clr7.bit", 64'(busy[7]), 64'(0));
    idle_inputs();
    // Same-cycle alloc and clear: alloc wins
    alloc_valid = 1; alloc_dest = 7; alu_valid = 1; alu_dest = 7; alu_data = 32'h78;
    step("alloc_vs_clr");
    check("alloc_vs_clr.bit", 64'(busy[7]), 64'(1));
    idle_inputs();

    // Build busy = 0xF0 then flush with alloc 3
    do_reset();
    for (int r = 4; r < 8; r++) begin
      alloc_valid = 1; alloc_dest = 5'(r);
      step("fill");
    end
    check("fill.busy", 64'(busy), 64'h0000_00F0);
    alloc_valid = 1; alloc_dest = 3; flush = 1;
    step("flush");
    check("flush.busy", 64'(busy), 64'(0));
    idle_inputs();

    // Reset dropped mid-handshake
    alloc_valid = 1; alloc_dest = 9;
    step("pre_rst");
    idle_inputs();
    alu_valid = 1; alu_dest = 9; alu_data = 32'hCAFE;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.alu_ready", 64'(alu_ready), 64'(0));
    check("midrst.wen", 64'(reg_write_en), 64'(0));
    check("midrst.dest", 64'(reg_write_dest), 64'(0));
    check("midrst.data", 64'(reg_write_data), 64'(0));
    check("midrst.busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    alu_valid = 0;
    model_reset();
    rst_n = 1'b1;
    step("post_rst");

    // Random traffic; producers hold until transferred
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || g_alu) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_data  = $urandom;
      end
      if (!lsu_valid || g_lsu) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
      alloc_valid = ($urandom_range(0, 99) < 40);
      alloc_dest  = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 99) < 4);
      step("rand");
    end
    idle_inputs();
    step("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter XLEN, 32, data width of results and register write data.
REQ-002 Parameter NREG, 32, register count; dest width is log2(NREG) = 5 at default.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 alu_valid / alu_ready  in / out  1 / 1  ALU result handshake.
REQ-006 alu_dest / alu_data  in  5 / XLEN  ALU destination register and result.
REQ-007 lsu_valid / lsu_ready  in / out  1 / 1  load-unit result handshake.
REQ-008 lsu_dest / lsu_data  in  5 / XLEN  load destination register and data.
REQ-009 alloc_valid / alloc_dest  in  1 / 5  issue stage claims a destination register as pending.
REQ-010 flush  in  1  synchronous clear of all pending claims.
REQ-011 reg_write_en / reg_write_dest / reg_write_data  out  1 / 5 / XLEN  registered register-file write port.
REQ-012 busy  out  NREG  per-register pending-write bitmap, registered.

Function
REQ-013 A transfer on a source occurs in a cycle where valid and ready are both high; the producer holds valid, dest and data stable until the transfer.
REQ-014 At most one source is granted per cycle; ready is driven only to the granted source and depends combinationally on both valids and last_grant.
REQ-015 Only one valid: that source is granted. Both valid: the source not named by last_grant is granted (round-robin). Neither valid: no grant and last_grant holds.
REQ-016 last_grant updates to the granted source on every transfer. Reset value is LSU, so ALU wins the first contention.
REQ-017 A transfer with dest != 0 sets reg_write_en = 1 for exactly the next cycle, with reg_write_dest and reg_write_data equal to the transferred values. Latency is 1 cycle.
REQ-018 A transfer with dest == 0 is accepted and consumed, but reg_write_en stays 0 for the following cycle.
REQ-019 While reg_write_en = 0, reg_write_dest and reg_write_data hold their last values.
REQ-020 alloc_valid with alloc_dest != 0 sets busy[alloc_dest] on the next edge. alloc_dest == 0 is ignored, so busy[0] is constantly 0.
REQ-021 A transfer with dest d != 0 clears busy[d] on the next edge.
REQ-022 If an alloc and a clearing transfer target the same register in the same cycle, the alloc wins and busy stays 1.
REQ-023 flush clears the whole busy bitmap on the next edge and overrides any alloc in the same cycle.
REQ-024 flush does not affect arbitration, transfers or register writes.
REQ-025 A transfer to a register whose busy bit is 0 is legal: the write still occurs and busy stays 0.

Reset
REQ-026 While rst_n = 0, the block asynchronously forces reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0, busy = 0 and last_grant = LSU.
REQ-027 While rst_n = 0, alu_ready and lsu_ready are 0.
REQ-028 Reset asserted mid-operation discards any transfer in that cycle, and no write is emitted after release.
REQ-029 The first grant is possible in the first cycle with rst_n = 1.

Structure
REQ-030 Shared package wb_pkg holds XLEN, NREG, REG_ADDR_W = 5 and the source encoding SRC_ALU = 0, SRC_LSU = 1.
REQ-031 A sub-module wb_rr_arb implements the two-requester round-robin grant and last_grant state.
REQ-032 The top level holds the output register and the busy bitmap.

Verification
REQ-033 Reset release, then alu_valid with dest 5 and data 0xDEADBEEF -> next cycle reg_write_en = 1, reg_write_dest = 5, reg_write_data = 0xDEADBEEF; following cycle reg_write_en = 0.
REQ-034 Both sources valid for 4 cycles (ALU dest 1, LSU dest 2) -> grants in order ALU, LSU, ALU, LSU; writes to x1, x2, x1, x2 each one cycle later.
REQ-035 lsu_valid with dest 0 and data 0x1234 -> lsu_ready = 1 and no reg_write_en pulse.
REQ-036 alloc_dest 7, then two cycles later an ALU transfer to 7 -> busy[7] = 1 for 2 cycles, then 0; in a second run, same-cycle alloc 7 and transfer 7 -> busy[7] stays 1.
REQ-037 busy = 0x0000_00F0 with flush and alloc_dest 3 asserted together -> busy = 0 next cycle.
REQ-038 rst_n dropped during a handshake -> all outputs 0 immediately, and no write pulse after release.
